// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rst_seq_pkg                                                          |
// | State encoding, default timing constants and counter sizing for      |
// | reset_sequencer.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_MMCM_RST  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_REL_TX    = 3'd3,
        S_REL_RX    = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } rst_seq_state_t;

    localparam int DEF_MMCM_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT    = 100000;
    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_STAGE_GAP       = 16;
    localparam int DEF_MAX_RETRIES     = 3;

    // Wide enough to hold the largest count value itself, not just count-1.
    function automatic int cntWidth(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lock_sync                                                            |
// | Two-flop synchronizer for an asynchronous MMCM locked indication.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lock_sync (
    input  logic clk,
    input  logic i_async,
    output logic o_sync
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        r_sync <= {r_sync[0], i_async};
    end

    assign o_sync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reset_sequencer                                                      |
// | Lock-aware MMCM reset controller with ordered tx/rx/250 release.     |
// | Optional: RST_SEQ_LOCK_STATS_EN enables the lock-loss counter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       mmcm0LockedIn,
    input  logic       mmcm1LockedIn,
    output logic       mmcmRstOut,
    output logic       rstTxReqOut,
    output logic       rstRxReqOut,
    output logic       rst250ReqOut,
    output logic       readyOut,
    output logic       faultOut,
    output logic [7:0] lockLossCntOut
);

    localparam int c_cntW = cntWidth(MMCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);

    localparam logic [c_cntW-1:0] c_rstLoad     = c_cntW'(MMCM_RST_CYCLES);
    localparam logic [c_cntW-1:0] c_mmcmLoad    = c_cntW'(MMCM_RST_CYCLES - 1);
    localparam logic [c_cntW-1:0] c_timeoutLoad = c_cntW'(LOCK_TIMEOUT - 1);
    localparam logic [c_cntW-1:0] c_stableLoad  = c_cntW'(STABLE_CYCLES - 1);
    localparam logic [c_cntW-1:0] c_gapLoad     = c_cntW'(STAGE_GAP - 1);
    localparam logic [1:0]        c_maxRetries  = 2'(MAX_RETRIES);

    logic w_lock0;
    logic w_lock1;
    logic w_lockOk;

    lock_sync u_sync0 (.clk(clkIn), .i_async(mmcm0LockedIn), .o_sync(w_lock0));
    lock_sync u_sync1 (.clk(clkIn), .i_async(mmcm1LockedIn), .o_sync(w_lock1));

    assign w_lockOk = w_lock0 & w_lock1;

    rst_seq_state_t    r_state;
    rst_seq_state_t    w_nextState;
    logic [c_cntW-1:0] r_cnt;
    logic [c_cntW-1:0] w_load;
    logic [1:0]        r_retry;
    logic [1:0]        w_retryInc;
    logic              w_timeout;
    logic              w_cntDone;

    assign w_cntDone  = (r_cnt == '0);
    assign w_retryInc = r_retry + 2'd1;
    assign w_timeout  = (r_state == S_WAIT_LOCK) && !w_lockOk && w_cntDone;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_MMCM_RST:  if (w_cntDone) w_nextState = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_lockOk)
                    w_nextState = S_STABLE;
                else if (w_cntDone)
                    w_nextState = (w_retryInc == c_maxRetries) ? S_FAULT : S_MMCM_RST;
            end
            S_STABLE: begin
                if (!w_lockOk)      w_nextState = S_WAIT_LOCK;
                else if (w_cntDone) w_nextState = S_REL_TX;
            end
            S_REL_TX: begin
                if (!w_lockOk)      w_nextState = S_WAIT_LOCK;
                else if (w_cntDone) w_nextState = S_REL_RX;
            end
            S_REL_RX: begin
                if (!w_lockOk)      w_nextState = S_WAIT_LOCK;
                else if (w_cntDone) w_nextState = S_RUN;
            end
            S_RUN:   if (!w_lockOk) w_nextState = S_WAIT_LOCK;
            S_FAULT: w_nextState = S_FAULT;
            default: w_nextState = S_MMCM_RST;
        endcase
    end

    always_comb begin
        w_load = '0;
        case (w_nextState)
            S_MMCM_RST:  w_load = c_mmcmLoad;
            S_WAIT_LOCK: w_load = c_timeoutLoad;
            S_STABLE:    w_load = c_stableLoad;
            S_REL_TX:    w_load = c_gapLoad;
            S_REL_RX:    w_load = c_gapLoad;
            default:     w_load = '0;
        endcase
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_state      <= S_MMCM_RST;
            // The reset edge is cycle 0, so this load spans cycles 1..MMCM_RST_CYCLES.
            r_cnt        <= c_rstLoad;
            r_retry      <= 2'd0;
            mmcmRstOut   <= 1'b1;
            rstTxReqOut  <= 1'b1;
            rstRxReqOut  <= 1'b1;
            rst250ReqOut <= 1'b1;
            readyOut     <= 1'b0;
            faultOut     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state)
                r_cnt <= w_load;
            else if (!w_cntDone)
                r_cnt <= r_cnt - c_cntW'(1);
            if (w_timeout)
                r_retry <= w_retryInc;
            else if (w_nextState == S_RUN && r_state != S_RUN)
                r_retry <= 2'd0;
            mmcmRstOut   <= (w_nextState == S_MMCM_RST);
            rstTxReqOut  <= !(w_nextState inside {S_REL_TX, S_REL_RX, S_RUN});
            rstRxReqOut  <= !(w_nextState inside {S_REL_RX, S_RUN});
            rst250ReqOut <= (w_nextState != S_RUN);
            readyOut     <= (w_nextState == S_RUN);
            faultOut     <= (w_nextState == S_FAULT);
        end
    end

`ifdef RST_SEQ_LOCK_STATS_EN
    logic       w_lockLoss;
    logic [7:0] r_lossCnt;

    assign w_lockLoss = !w_lockOk && (r_state inside {S_REL_TX, S_REL_RX, S_RUN});

    always_ff @(posedge clkIn) begin
        if (rstIn)
            r_lossCnt <= 8'd0;
        else if (w_lockLoss && r_lossCnt != 8'hFF)
            r_lossCnt <= r_lossCnt + 8'd1;
    end

    assign lockLossCntOut = r_lossCnt;
`else
    assign lockLossCntOut = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reset_sequencer                                                   |
// | Directed table-driven bench for reset_sequencer (small timing set).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reset_sequencer;

    logic       clkIn = 1'b0;
    logic       rstIn;
    logic       mmcm0LockedIn;
    logic       mmcm1LockedIn;
    logic       mmcmRstOut;
    logic       rstTxReqOut;
    logic       rstRxReqOut;
    logic       rst250ReqOut;
    logic       readyOut;
    logic       faultOut;
    logic [7:0] lockLossCntOut;

    always #5 clkIn = ~clkIn;

    reset_sequencer #(
        .MMCM_RST_CYCLES(4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (8),
        .STAGE_GAP      (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clkIn         (clkIn),
        .rstIn         (rstIn),
        .mmcm0LockedIn (mmcm0LockedIn),
        .mmcm1LockedIn (mmcm1LockedIn),
        .mmcmRstOut    (mmcmRstOut),
        .rstTxReqOut   (rstTxReqOut),
        .rstRxReqOut   (rstRxReqOut),
        .rst250ReqOut  (rst250ReqOut),
        .readyOut      (readyOut),
        .faultOut      (faultOut),
        .lockLossCntOut(lockLossCntOut)
    );

`ifdef RST_SEQ_LOCK_STATS_EN
    localparam logic [7:0] c_expLoss = 8'd1;
`else
    localparam logic [7:0] c_expLoss = 8'd0;
`endif

    // {pulses[3:0], mmcmRst, tx, rx, r250, ready, fault, lossCnt[7:0]}
    typedef struct {
        bit          rst;
        int          cyc;
        bit          l0;
        bit          l1;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   checks;
    int   errors;
    int   pulses;
    logic prevMmcm;

    function automatic logic [17:0] mk(int p, bit m, bit t, bit r, bit q, bit rd, bit f, logic [7:0] c);
        return {4'(p), m, t, r, q, rd, f, c};
    endfunction

    task automatic add(bit r, int c, bit a, bit b, logic [17:0] e, string n);
        vec_t v;
        v.rst = r; v.cyc = c; v.l0 = a; v.l1 = b; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [17:0] exp);
        logic [17:0] obs;
        obs = {4'(pulses), mmcmRstOut, rstTxReqOut, rstRxReqOut, rst250ReqOut,
               readyOut, faultOut, lockLossCntOut};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, obs, exp);
        end
    endtask

    // Release order and ready/fault consistency must hold on every cycle.
    task automatic orderCheck();
        logic bad;
        bad = (!rstRxReqOut && rstTxReqOut) || (!rst250ReqOut && rstRxReqOut) ||
              (readyOut != !rst250ReqOut) ||
              (faultOut && !(rstTxReqOut && rstRxReqOut && rst250ReqOut && !mmcmRstOut));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL order cyc=%0d got=%b%b%b%b%b%b", cyc, mmcmRstOut, rstTxReqOut,
                     rstRxReqOut, rst250ReqOut, readyOut, faultOut);
        end
    endtask

    // All tasks start and end at a negedge; inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clkIn);
        @(negedge clkIn);
        cyc++;
        if (mmcmRstOut && !prevMmcm) pulses++;
        prevMmcm = mmcmRstOut;
        orderCheck();
    endtask

    task automatic stepTo(int n);
        while (cyc < n) step();
    endtask

    task automatic doReset(bit a, bit b);
        mmcm0LockedIn = a;
        mmcm1LockedIn = b;
        rstIn = 1'b1;
        @(posedge clkIn);
        @(negedge clkIn);
        rstIn    = 1'b0;
        cyc      = 0;
        pulses   = mmcmRstOut ? 1 : 0;
        prevMmcm = mmcmRstOut;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; pulses = 0; prevMmcm = 1'b0;
        rstIn = 1'b1; mmcm0LockedIn = 1'b1; mmcm1LockedIn = 1'b1;

        // Happy path
        add(1,  0, 1, 1, mk(1,1,1,1,1,0,0,0), "A_reset");
        add(0,  1, 1, 1, mk(1,1,1,1,1,0,0,0), "A_mmcm1");
        add(0,  4, 1, 1, mk(1,1,1,1,1,0,0,0), "A_mmcm4");
        add(0,  5, 1, 1, mk(1,0,1,1,1,0,0,0), "A_mmcm5");
        add(0, 13, 1, 1, mk(1,0,1,1,1,0,0,0), "A_tx13");
        add(0, 14, 1, 1, mk(1,0,0,1,1,0,0,0), "A_tx14");
        add(0, 17, 1, 1, mk(1,0,0,1,1,0,0,0), "A_rx17");
        add(0, 18, 1, 1, mk(1,0,0,0,1,0,0,0), "A_rx18");
        add(0, 21, 1, 1, mk(1,0,0,0,1,0,0,0), "A_run21");
        add(0, 22, 1, 1, mk(1,0,0,0,0,1,0,0), "A_run22");
        add(0, 40, 1, 1, mk(1,0,0,0,0,1,0,0), "A_run40");
        // Late lock: mmcm1 rises after edge 20, STABLE entered at 23
        add(1,  0, 1, 0, mk(1,1,1,1,1,0,0,0), "B_reset");
        add(0,  5, 1, 0, mk(1,0,1,1,1,0,0,0), "B_wait5");
        add(0, 20, 1, 1, mk(1,0,1,1,1,0,0,0), "B_wait20");
        add(0, 30, 1, 1, mk(1,0,1,1,1,0,0,0), "B_tx30");
        add(0, 31, 1, 1, mk(1,0,0,1,1,0,0,0), "B_tx31");
        add(0, 35, 1, 1, mk(1,0,0,0,1,0,0,0), "B_rx35");
        add(0, 38, 1, 1, mk(1,0,0,0,1,0,0,0), "B_run38");
        add(0, 39, 1, 1, mk(1,0,0,0,0,1,0,0), "B_run39");
        // Never locks: two MMCM pulses, FAULT at the second timeout
        add(1,  0, 0, 0, mk(1,1,1,1,1,0,0,0), "C_reset");
        add(0, 36, 0, 0, mk(1,0,1,1,1,0,0,0), "C_to36");
        add(0, 37, 0, 0, mk(2,1,1,1,1,0,0,0), "C_retry37");
        add(0, 40, 0, 0, mk(2,1,1,1,1,0,0,0), "C_retry40");
        add(0, 41, 0, 0, mk(2,0,1,1,1,0,0,0), "C_wait41");
        add(0, 72, 0, 0, mk(2,0,1,1,1,0,0,0), "C_wait72");
        add(0, 73, 1, 1, mk(2,0,1,1,1,0,1,0), "C_fault73");
        add(0,100, 1, 1, mk(2,0,1,1,1,0,1,0), "C_fault100");
        // Glitch in STABLE: one-cycle drop, full recount, release at 20
        add(1,  0, 1, 1, mk(1,1,1,1,1,0,0,0), "D_reset");
        add(0,  8, 0, 1, mk(1,0,1,1,1,0,0,0), "D_glitch8");
        add(0,  9, 1, 1, mk(1,0,1,1,1,0,0,0), "D_glitch9");
        add(0, 14, 1, 1, mk(1,0,1,1,1,0,0,0), "D_tx14");
        add(0, 19, 1, 1, mk(1,0,1,1,1,0,0,0), "D_tx19");
        add(0, 20, 1, 1, mk(1,0,0,1,1,0,0,0), "D_tx20");
        add(0, 24, 1, 1, mk(1,0,0,0,1,0,0,0), "D_rx24");
        add(0, 27, 1, 1, mk(1,0,0,0,1,0,0,0), "D_rx27");
        add(0, 28, 1, 1, mk(1,0,0,0,0,1,0,0), "D_run28");

        @(negedge clkIn);
        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset(vecs[i].l0, vecs[i].l1);
            else             stepTo(vecs[i].cyc);
            check(vecs[i].name, vecs[i].exp);
            mmcm0LockedIn = vecs[i].l0;
            mmcm1LockedIn = vecs[i].l1;
        end

        // Runtime loss in RUN: requests back exactly 3 edges after the drop
        doReset(1'b1, 1'b1);
        stepTo(30);
        check("E_run30", mk(1,0,0,0,0,1,0,0));
        mmcm1LockedIn = 1'b0;
        step(); step();
        check("E_hold32", mk(1,0,0,0,0,1,0,0));
        step();
        check("E_loss33", mk(1,0,1,1,1,0,0,c_expLoss));
        mmcm1LockedIn = 1'b1;
        stepTo(43);
        check("E_tx43", mk(1,0,1,1,1,0,0,c_expLoss));
        stepTo(44);
        check("E_tx44", mk(1,0,0,1,1,0,0,c_expLoss));
        stepTo(48);
        check("E_rx48", mk(1,0,0,0,1,0,0,c_expLoss));

        // Mid-release reset during REL_RX
        stepTo(49);
        rstIn = 1'b1;
        step();
        check("F_reset", mk(2,1,1,1,1,0,0,0));
        rstIn = 1'b0;
        cyc = 0; pulses = 1; prevMmcm = mmcmRstOut;
        stepTo(13);
        check("F_tx13", mk(1,0,1,1,1,0,0,0));
        stepTo(14);
        check("F_tx14", mk(1,0,0,1,1,0,0,0));
        stepTo(22);
        check("F_run22", mk(1,0,0,0,0,1,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Lock-aware reset controller on the 100 MHz board clock that drives the MMCM resets and consumes the MMCM `locked` outputs. It releases the per-domain reset requests in a fixed order: tx, then rx, then 250 MHz. Each request feeds the per-domain 3-flop synchronizers. The block retries MMCMs that fail to lock, and re-enters reset whenever lock is lost at runtime.

## Interface
- `MMCM_RST_CYCLES`, default 16: cycles `mmcmRstOut` is held high per attempt.
- `LOCK_TIMEOUT`, default 100000: cycles allowed in WAIT_LOCK before a retry.
- `STABLE_CYCLES`, default 1024: consecutive cycles both locks must hold before any release.
- `STAGE_GAP`, default 16: cycles between successive domain releases.
- `MAX_RETRIES`, default 3: failed lock attempts before FAULT.
- `clkIn` in 1: 100 MHz board clock, the only clock.
- `rstIn` in 1: synchronous, active-high reset.
- `mmcm0LockedIn` in 1: MMCM0 locked, asynchronous.
- `mmcm1LockedIn` in 1: MMCM1 locked, asynchronous.
- `mmcmRstOut` out 1: reset to both MMCMs.
- `rstTxReqOut` out 1: tx/txLcl domain reset request.
- `rstRxReqOut` out 1: rxLcl domain reset request.
- `rst250ReqOut` out 1: 250 MHz domain reset request.
- `readyOut` out 1: all domains released.
- `faultOut` out 1: retries exhausted.
- `lockLossCntOut` out 8: saturating runtime lock-loss count.

## Operation
- Both locked inputs pass through a 2-flop synchronizer; `lockOk` is the AND of the two synchronized bits.
- One shared down-counter, sized by `$clog2` of the largest parameter. A 2-bit retry counter.
- **States:** MMCM_RST, WAIT_LOCK, STABLE, REL_TX, REL_RX, RUN, FAULT.
- **MMCM_RST:** `mmcmRstOut`=1 for `MMCM_RST_CYCLES` cycles, then WAIT_LOCK.
- **WAIT_LOCK:** `lockOk` moves to STABLE on the next cycle.
  - After `LOCK_TIMEOUT` cycles without lock, increment retry.
  - If retry==`MAX_RETRIES`, go to FAULT; otherwise go to MMCM_RST.
  - If lock and timeout occur on the same cycle, lock wins.
- **STABLE:** `lockOk` must stay high for `STABLE_CYCLES` consecutive cycles.
  - Any drop returns to WAIT_LOCK. The timeout restarts and retry is unchanged.
  - A drop on the final cycle also returns to WAIT_LOCK; the drop wins.
- **REL_TX:** `rstTxReqOut`=0 for `STAGE_GAP` cycles, then REL_RX.
- **REL_RX:** `rstRxReqOut`=0 for `STAGE_GAP` cycles, then RUN.
- **RUN:** `rst250ReqOut`=0 and `readyOut`=1. Retry counter clears on RUN entry.
- **Lock loss in REL_TX, REL_RX or RUN:**
  - All three requests reassert and `readyOut`=0 on the next cycle; state goes to WAIT_LOCK.
  - `mmcmRstOut` is not pulsed.
  - `lockLossCntOut` increments and saturates at 255.
- **FAULT:** terminal. `faultOut`=1, all requests high, `mmcmRstOut`=0. Only `rstIn` exits FAULT.
- A request may be low only in its own release state or a later one. Release order is never violated, including on re-entry.

## Timing
- All outputs are registered Moore decodes of the state, so an output changes on the edge that enters its state.
- **Reset values:**
  - `mmcmRstOut`=1.
  - `rstTxReqOut`, `rstRxReqOut`, `rst250ReqOut` = 1.
  - `readyOut`=0, `faultOut`=0, `lockLossCntOut`=0.
  - State is MMCM_RST; counters are loaded.
- `rstIn` asserted in any state returns the block to the reset values on the next edge.
- Cycle numbering: cycle n is the nth `clkIn` edge after `rstIn` is sampled low.
- With locks already high, occupancy is:
  - MMCM_RST: `MMCM_RST_CYCLES` cycles.
  - WAIT_LOCK: 1 cycle.
  - STABLE: `STABLE_CYCLES` cycles.
  - REL_TX: `STAGE_GAP` cycles.
  - REL_RX: `STAGE_GAP` cycles.
- Lock edge to `lockOk` latency: 2 cycles.
- Lock loss to requests reasserted: 3 cycles (synchronizer plus output register).

## Configuration
- `RST_SEQ_LOCK_STATS_EN` defined: the saturating lock-loss counter drives `lockLossCntOut`.
- Not defined: the counter is removed and `lockLossCntOut` is tied to 0. All other behaviour is identical.

## Structure
- `rst_seq_pkg` holds:
  - the `rst_seq_state_t` enum;
  - default parameter constants;
  - the counter width function.
- Sub-module `lock_sync`: 2-flop synchronizer with ASYNC_REG, instantiated once per locked input.

## Test plan
Bench parameters: `MMCM_RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `STAGE_GAP`=4, `MAX_RETRIES`=2.
- **Happy path.** Locks high throughout.
  - `mmcmRstOut` is high in cycles 1-4.
  - `rstTxReqOut` falls at cycle 14, `rstRxReqOut` at 18.
  - `rst250ReqOut` falls and `readyOut` rises at 22.
- **Late lock.** `mmcm1LockedIn` rises at cycle 20 → STABLE is entered at cycle 23; release occurs 8 cycles later; `mmcmRstOut` pulses once.
- **Never locks.**
  - `mmcmRstOut` pulses twice.
  - `faultOut`=1 after the second timeout and stays high while locks later go high.
  - `rstIn` clears it.
- **Glitch in STABLE.** `mmcm0LockedIn` goes low for 1 cycle mid-STABLE → no release; the full 8 stable cycles are re-counted; `lockLossCntOut` stays 0.
- **Runtime loss in RUN.**
  - `mmcm1LockedIn` drops → all requests high and `readyOut`=0 exactly 3 cycles later.
  - `lockLossCntOut`=1.
  - Relock causes ordered re-release with no `mmcmRstOut` pulse.
- **Mid-release reset.** `rstIn` pulses during REL_RX → the next edge shows all requests high, `mmcmRstOut`=1, and the counters reset.
